// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_stack_unit
// Description : Program counter with increment, branch, jump, call/return.
//               All state changes on the falling clock edge. Define
//               PC_STACK_EN to build the return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int               WIDTH        = 16,
    parameter int               TOP_BITS     = 3,
    parameter int               INC_STEP     = 2,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                PCWrite,
    input  logic [2:0]          PCSrc,
    input  logic [WIDTH-1:0]    Din,
    input  logic                ClearFault,
    output logic [WIDTH-1:0]    Out,
    output logic [TOP_BITS-1:0] TopOut,
    output logic                StackEmpty,
    output logic                StackFull,
    output logic                Overflow,
    output logic                Underflow
);

    localparam logic [2:0] SRC_INC    = 3'd0;
    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JREG   = 3'd3;
    localparam logic [2:0] SRC_CALL   = 3'd4;
    localparam logic [2:0] SRC_RET    = 3'd5;

    localparam logic [WIDTH-1:0] INC_VAL = WIDTH'(INC_STEP);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_branch;
    logic [WIDTH-1:0] w_jump;

    assign w_inc    = pc_q + INC_VAL;
    assign w_branch = pc_q + Din;
    assign w_jump   = {pc_q[WIDTH-1 -: TOP_BITS], Din[WIDTH-TOP_BITS-1:0]};

`ifdef PC_STACK_EN
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [WIDTH-1:0] stack_d [STACK_DEPTH];
    logic             w_empty;
    logic             w_full;
    logic [IDX_W-1:0] w_top_idx;

    assign w_empty   = (ptr_q == '0);
    assign w_full    = (ptr_q == PTR_W'(STACK_DEPTH));
    // Low bits wrap correctly even when ptr_q == STACK_DEPTH.
    assign w_top_idx = ptr_q[IDX_W-1:0] - IDX_W'(1);

    always_comb begin
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        stack_d     = stack_q;
        overflow_d  = overflow_q & ~ClearFault;
        underflow_d = underflow_q & ~ClearFault;
        if (PCWrite) begin
            case (PCSrc)
                SRC_INC:    pc_d = w_inc;
                SRC_BRANCH: pc_d = w_branch;
                SRC_JUMP:   pc_d = w_jump;
                SRC_JREG:   pc_d = Din;
                SRC_CALL: begin
                    pc_d = w_jump;
                    if (w_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        stack_d[ptr_q[IDX_W-1:0]] = w_inc;
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end
                SRC_RET: begin
                    if (w_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        pc_d  = stack_q[w_top_idx];
                        ptr_d = ptr_q - PTR_W'(1);
                    end
                end
                default:    underflow_d = 1'b1;
            endcase
        end
    end

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Stack storage carries no reset; the pointer alone defines validity.
    always_ff @(negedge CLK) begin
        stack_q <= stack_d;
    end

    assign StackEmpty = w_empty;
    assign StackFull  = w_full;
    assign Overflow   = overflow_q;
`else
    always_comb begin
        pc_d        = pc_q;
        underflow_d = underflow_q & ~ClearFault;
        if (PCWrite) begin
            case (PCSrc)
                SRC_INC:    pc_d = w_inc;
                SRC_BRANCH: pc_d = w_branch;
                SRC_JUMP:   pc_d = w_jump;
                SRC_JREG:   pc_d = Din;
                SRC_CALL:   pc_d = w_jump;
                default:    underflow_d = 1'b1;
            endcase
        end
    end

    assign StackEmpty = 1'b1;
    assign StackFull  = 1'b0;
    assign Overflow   = 1'b0;
`endif

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q        <= RESET_VECTOR;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    assign Out       = pc_q;
    assign TopOut    = pc_q[WIDTH-1 -: TOP_BITS];
    assign Underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_stack_unit
// Description : Self-checking bench for pc_stack_unit: queue-based reference
//               model plus directed literal checks and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

    localparam int          WIDTH  = 16;
    localparam int          TOPB   = 3;
    localparam int          STEP   = 2;
    localparam int          DEPTH  = 4;
    localparam logic [15:0] RSTVEC = 16'h0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        PCWrite = 1'b0;
    logic [2:0]  PCSrc = 3'd0;
    logic [15:0] Din = 16'h0;
    logic        ClearFault = 1'b0;
    logic [15:0] Out;
    logic [2:0]  TopOut;
    logic        StackEmpty, StackFull, Overflow, Underflow;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    bit          m_ovf, m_unf;

    pc_stack_unit #(
        .WIDTH(WIDTH), .TOP_BITS(TOPB), .INC_STEP(STEP),
        .STACK_DEPTH(DEPTH), .RESET_VECTOR(RSTVEC)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .Din(Din), .ClearFault(ClearFault), .Out(Out), .TopOut(TopOut),
        .StackEmpty(StackEmpty), .StackFull(StackFull),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = RSTVEC;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic void model_step(bit pcw, logic [2:0] src, logic [15:0] din, bit clr);
        logic [15:0] jt;
        jt = (m_pc & 16'hE000) | (din & 16'h1FFF);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (pcw) begin
            case (src)
                3'd0: m_pc = m_pc + 16'(STEP);
                3'd1: m_pc = m_pc + din;
                3'd2: m_pc = jt;
                3'd3: m_pc = din;
                3'd4: begin
`ifdef PC_STACK_EN
                    if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 16'(STEP));
                    else m_ovf = 1'b1;
`endif
                    m_pc = jt;
                end
                3'd5: begin
`ifdef PC_STACK_EN
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else m_unf = 1'b1;
`else
                    m_unf = 1'b1;
`endif
                end
                default: m_unf = 1'b1;
            endcase
        end
    endfunction

    // Model state is updated just after each falling edge; compare on the rising edge.
    always @(posedge CLK) begin
        if (chk_en) begin
            check("out",       32'(Out),        32'(m_pc));
            check("topout",    32'(TopOut),     32'(m_pc[15:13]));
            check("empty",     32'(StackEmpty), 32'(m_stk.size() == 0));
            check("full",      32'(StackFull),  32'(m_stk.size() == DEPTH));
            check("overflow",  32'(Overflow),   32'(m_ovf));
            check("underflow", 32'(Underflow),  32'(m_unf));
        end
    end

    task automatic step(input bit pcw, input logic [2:0] src, input logic [15:0] din, input bit clr);
        PCWrite    = pcw;
        PCSrc      = src;
        Din        = din;
        ClearFault = clr;
        @(negedge CLK);
        #1;
        model_step(pcw, src, din, clr);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_reset();
        check("rst_out",   32'(Out),        32'h0000);
        check("rst_top",   32'(TopOut),     32'h0);
        check("rst_empty", 32'(StackEmpty), 32'h1);
        check("rst_full",  32'(StackFull),  32'h0);
        check("rst_flags", 32'({Overflow, Underflow}), 32'h0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();
        chk_en = 1'b1;

        step(1, 3'd3, 16'hFFFE, 0);
        step(0, 3'd0, 16'h0000, 0);
        check("hold_pcwrite0", 32'(Out), 32'hFFFE);
        step(1, 3'd0, 16'h0000, 0);
        check("inc_wrap", 32'(Out), 32'h0000);

        step(1, 3'd3, 16'h4010, 0);
        step(1, 3'd1, 16'hFFF0, 0);
        check("branch_neg", 32'(Out), 32'h4000);
        step(1, 3'd2, 16'h1234, 0);
        check("jump", 32'(Out), 32'h5234);
        check("jump_top", 32'(TopOut), 32'h2);

        step(1, 3'd3, 16'h0100, 0);
        step(1, 3'd4, 16'h0200, 0);
        check("call1", 32'(Out), 32'h0200);
        step(1, 3'd4, 16'h0300, 0);
        step(1, 3'd5, 16'h0000, 0);
`ifdef PC_STACK_EN
        check("ret1", 32'(Out), 32'h0202);
        step(1, 3'd5, 16'h0000, 0);
        check("ret2", 32'(Out), 32'h0102);
        check("ret2_empty", 32'(StackEmpty), 32'h1);
`else
        check("ret_nostack", 32'(Out), 32'h0300);
        check("ret_nostack_unf", 32'(Underflow), 32'h1);
        step(1, 3'd5, 16'h0000, 0);
`endif
        step(0, 3'd0, 16'h0000, 1);

        for (int k = 1; k <= 5; k++) begin
            step(1, 3'd4, 16'(16'h0010 * k), 0);
`ifdef PC_STACK_EN
            if (k == 4) check("full_after4", 32'(StackFull), 32'h1);
`endif
        end
        check("call5_target", 32'(Out), 32'h0050);
`ifdef PC_STACK_EN
        check("overflow", 32'(Overflow), 32'h1);
        for (int k = 0; k < 4; k++) step(1, 3'd5, 16'h0000, 0);
        check("ret4", 32'(Out), 32'h0104);
        step(1, 3'd5, 16'h0000, 0);
        check("ret5_hold", 32'(Out), 32'h0104);
`else
        check("no_overflow", 32'(Overflow), 32'h0);
        step(1, 3'd5, 16'h0000, 0);
        check("ret_hold", 32'(Out), 32'h0050);
`endif
        check("underflow", 32'(Underflow), 32'h1);
        step(0, 3'd0, 16'h0000, 1);
        check("clear_flags", 32'({Overflow, Underflow}), 32'h0);

        step(1, 3'd7, 16'hAAAA, 0);
        check("rsvd_unf", 32'(Underflow), 32'h1);
        step(1, 3'd6, 16'h5555, 1);
        check("clr_vs_set", 32'(Underflow), 32'h1);
        step(0, 3'd0, 16'h0000, 1);

        // Reset between CALL and RET discards the return address.
        step(1, 3'd3, 16'h0100, 0);
        step(1, 3'd4, 16'h0200, 0);
        do_reset();
        step(1, 3'd5, 16'h0000, 0);
        check("ret_after_rst", 32'(Out), 32'h0000);
        check("ret_after_rst_unf", 32'(Underflow), 32'h1);

`ifndef PC_STACK_EN
        step(1, 3'd4, 16'h0200, 0);
        check("call_as_jump", 32'(Out), 32'h0200);
        check("call_empty", 32'(StackEmpty), 32'h1);
`endif

        for (int i = 0; i < 600; i++) begin
            logic [2:0] src;
            if (i % 150 == 149) do_reset();
            src = ($urandom_range(0, 99) < 4) ? 3'(6 + $urandom_range(0, 1))
                                              : 3'($urandom_range(0, 5));
            step($urandom_range(0, 9) != 0, src, 16'($urandom),
                 $urandom_range(0, 15) == 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
